// File: rtl/shift_reg_piso.sv
// shift_reg_piso: parallel-in/serial-out shifter, STEP bits per beat, zero-bubble reload.
// Optional serial capture path enabled by defining SHIFT_REG_CAPTURE_EN.
module shift_reg_piso #(
   parameter int WIDTH     = 32,
   parameter int STEP      = 2,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic             load_ready,
   output logic [STEP-1:0]  ser_out,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             ser_last,
   input  logic [STEP-1:0]  ser_in,
   output logic [WIDTH-1:0] cap_data,
   output logic             cap_valid
);
   localparam int BEATS = WIDTH / STEP;
   localparam int CW    = $clog2(BEATS + 1);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t           state, state_nx;
   logic [WIDTH-1:0] sr, sr_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic             xfer, acc;
   assign ser_valid  = state == SHIFT;
   assign ser_last   = ser_valid && cnt == CW'(1);
   assign ser_out    = MSB_FIRST != 0 ? sr[WIDTH-1 -: STEP] : sr[STEP-1:0];
   assign load_ready = !ser_valid || (ser_last && ser_ready);
   assign xfer       = ser_valid && ser_ready;
   assign acc        = load_valid && load_ready;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         sr    <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         sr    <= sr_nx;
         cnt   <= cnt_nx;
      end
   // A load on the last beat takes priority so the next word follows with no bubble
   always_comb begin
      state_nx = acc ? SHIFT : xfer ? (ser_last ? IDLE : SHIFT) : state;
      sr_nx    = acc ? load_data : xfer ? (MSB_FIRST != 0 ? sr << STEP : sr >> STEP) : sr;
      cnt_nx   = acc ? CW'(BEATS) : xfer ? cnt - CW'(1) : cnt;
   end
`ifdef SHIFT_REG_CAPTURE_EN
   logic [WIDTH-1:0] cr, cr_in;
   assign cr_in = MSB_FIRST != 0 ? (cr << STEP) | WIDTH'(ser_in)
                                 : (cr >> STEP) | (WIDTH'(ser_in) << (WIDTH - STEP));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cr        <= '0;
         cap_data  <= '0;
         cap_valid <= 1'b0;
      end else begin
         cr        <= acc ? '0 : xfer ? cr_in : cr;
         cap_data  <= xfer && ser_last ? cr_in : cap_data;
         cap_valid <= xfer && ser_last;
      end
`else
   logic unused_ser_in;
   assign unused_ser_in = ^ser_in;
   assign cap_data      = '0;
   assign cap_valid     = 1'b0;
`endif
endmodule

// File: tb/tb_shift_reg_piso.sv
// tb_shift_reg_piso: queue-based beat model checked every cycle, plus directed literal checks.
module tb_shift_reg_piso;
`ifdef SHIFT_REG_CAPTURE_EN
   localparam bit CAP = 1'b1;
`else
   localparam bit CAP = 1'b0;
`endif
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [31:0] load_data = '0, cap_data;
   logic        load_valid = 1'b0, load_ready, ser_valid, ser_ready = 1'b1, ser_last, cap_valid;
   logic [1:0]  ser_out, ser_in;
   logic [31:0] b_data = '0, b_cap_data;
   logic        b_valid = 1'b0, b_lready, b_svalid, b_last, b_cap_valid;
   logic [1:0]  b_out, b_in;
   always #5 clk = ~clk;
   assign ser_in = ser_out;
   assign b_in   = b_out;

   shift_reg_piso #(.WIDTH(32), .STEP(2), .MSB_FIRST(1)) dut (
      .clk(clk), .rst_n(rst_n), .load_data(load_data), .load_valid(load_valid),
      .load_ready(load_ready), .ser_out(ser_out), .ser_valid(ser_valid),
      .ser_ready(ser_ready), .ser_last(ser_last), .ser_in(ser_in),
      .cap_data(cap_data), .cap_valid(cap_valid));

   shift_reg_piso #(.WIDTH(32), .STEP(2), .MSB_FIRST(0)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .load_data(b_data), .load_valid(b_valid),
      .load_ready(b_lready), .ser_out(b_out), .ser_valid(b_svalid),
      .ser_ready(1'b1), .ser_last(b_last), .ser_in(b_in),
      .cap_data(b_cap_data), .cap_valid(b_cap_valid));

   int tests = 0, fails = 0, cyc = 0, cv_cnt = 0, cv_cyc = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: each accepted word becomes 16 queued beats (top two bits first)
   typedef struct {logic [1:0] b; logic [31:0] w;} beat_t;
   beat_t       q[$];
   beat_t       e;
   logic [31:0] e_cd = '0;
   logic        e_cv = 1'b0;
   bit          m_rdy;
   logic [1:0]  obs[$];
   bit          obs_last[$];
   int          obs_cyc[$];

   initial forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
         q.delete();
         e_cd = '0;
         e_cv = 1'b0;
      end
      m_rdy = q.size() == 0 || (q.size() == 1 && ser_ready);
      chk("ser_valid", ser_valid, q.size() > 0);
      chk("ser_out", ser_out, q.size() > 0 ? q[0].b : 2'b00);
      chk("ser_last", ser_last, q.size() == 1);
      chk("load_ready", load_ready, m_rdy);
      chk("cap_valid", cap_valid, e_cv);
      chk("cap_data", cap_data, e_cd);
      if (rst_n && ser_valid && ser_ready) begin
         obs.push_back(ser_out);
         obs_last.push_back(ser_last);
         obs_cyc.push_back(cyc);
      end
      if (cap_valid) begin
         cv_cnt++;
         cv_cyc = cyc;
      end
      if (rst_n) begin
         e_cv = 1'b0;
         if (q.size() > 0 && ser_ready) begin
            if (q.size() == 1 && CAP) begin
               e_cv = 1'b1;
               e_cd = q[0].w;
            end
            void'(q.pop_front());
         end
         if (load_valid && m_rdy)
            for (int i = 0; i < 16; i++) begin
               e.b = 2'((load_data >> (30 - 2 * i)) & 32'h3);
               e.w = load_data;
               q.push_back(e);
            end
      end
   end

   task automatic wait_acc();
      int k;
      for (k = 0; k < 100; k++) begin
         @(negedge clk);
         if (load_ready) break;
      end
      if (k == 100) chk("accept timeout", 0, 1);
   endtask

   task automatic send(input logic [31:0] w);
      @(posedge clk);
      #1 load_data = w;
      load_valid = 1'b1;
      wait_acc();
      @(posedge clk);
      #1 load_valid = 1'b0;
   endtask

   task automatic wait_beats(input int n);
      for (int k = 0; k < 200 && obs.size() < n; k++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("beat count", obs.size(), n);
   endtask

   task automatic check_c001(input string name);
      for (int i = 0; i < 16; i++) begin
         chk({name, " beat"}, obs[i], i == 0 ? 2'b11 : i == 15 ? 2'b01 : 2'b00);
         chk({name, " last"}, obs_last[i], i == 15);
      end
   endtask

   initial begin
      int n0;
      repeat (2) @(negedge clk);
      chk("rst ser_valid", ser_valid, 0);
      chk("rst ser_out", ser_out, 0);
      chk("rst ser_last", ser_last, 0);
      chk("rst cap_data", cap_data, 0);
      chk("rst cap_valid", cap_valid, 0);
      #2 rst_n = 1'b1;
      // basic word, free-flowing sink
      obs.delete(); obs_last.delete(); obs_cyc.delete();
      send(32'hC000_0001);
      wait_beats(16);
      check_c001("t1");
      chk("t1 idle", ser_valid, 0);
      // stall mid-word
      obs.delete(); obs_last.delete(); obs_cyc.delete();
      send(32'hC000_0001);
      for (int k = 0; k < 100 && obs.size() < 2; k++) @(negedge clk);
      @(posedge clk);
      #1 ser_ready = 1'b0;
      n0 = obs.size();
      repeat (5) begin
         @(negedge clk);
         chk("t2 stall out", ser_out, 2'b00);
         chk("t2 stall valid", ser_valid, 1);
      end
      chk("t2 stall count", obs.size(), n0);
      @(posedge clk);
      #1 ser_ready = 1'b1;
      wait_beats(16);
      check_c001("t2");
      // back-to-back words
      obs.delete(); obs_last.delete(); obs_cyc.delete();
      @(posedge clk);
      #1 load_data = 32'hAAAA_AAAA;
      load_valid = 1'b1;
      wait_acc();
      @(posedge clk);
      #1 load_data = 32'h5555_5555;
      wait_acc();
      @(posedge clk);
      #1 load_valid = 1'b0;
      wait_beats(32);
      for (int i = 0; i < 32; i++) begin
         chk("t3 beat", obs[i], i < 16 ? 2'b10 : 2'b01);
         chk("t3 last", obs_last[i], i == 15 || i == 31);
      end
      chk("t3 no bubble", obs_cyc[31] - obs_cyc[0], 31);
      // asynchronous reset mid-word
      obs.delete(); obs_last.delete(); obs_cyc.delete();
      send(32'hFFFF_FFFF);
      for (int k = 0; k < 100 && obs.size() < 6; k++) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("t4 async valid", ser_valid, 0);
      chk("t4 async out", ser_out, 0);
      chk("t4 async last", ser_last, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("t4 post-reset idle", ser_valid, 0);
      obs.delete(); obs_last.delete(); obs_cyc.delete();
      send(32'h0000_000F);
      wait_beats(16);
      for (int i = 0; i < 16; i++) chk("t4 beat", obs[i], i < 14 ? 2'b00 : 2'b11);
      // LSB-first instance
      @(posedge clk);
      #1 b_data = 32'h0000_0006;
      b_valid = 1'b1;
      @(posedge clk);
      #1 b_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("t5 beat", b_out, i == 0 ? 2'b10 : i == 1 ? 2'b01 : 2'b00);
         chk("t5 valid", b_svalid, 1);
         chk("t5 last", b_last, i == 15);
      end
      @(negedge clk);
      chk("t5 idle", b_svalid, 0);
      // capture loopback
      obs.delete(); obs_last.delete(); obs_cyc.delete();
      cv_cnt = 0;
      cv_cyc = 0;
      send(32'hDEAD_BEEF);
      wait_beats(16);
      chk("t6 pulses", cv_cnt, CAP ? 1 : 0);
      chk("t6 pulse cycle", cv_cyc, CAP ? obs_cyc[15] + 1 : 0);
      chk("t6 cap_data", cap_data, CAP ? 32'hDEAD_BEEF : 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end
endmodule
